// File: rtl/color_box_tracker.sv
// rtl/color_box_tracker.sv - per-pixel chroma persistence tracker with per-frame bounding box
// History RAM keeps the last HIST_BITS match results per pixel; a 2-stage read-modify-write pipeline updates it.
module color_box_tracker #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int HIST_BITS = 4,
  parameter int PERSIST   = 3,
  parameter int CW        = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pix_valid,
  input  logic [9:0]                           x,
  input  logic [9:0]                           y,
  input  logic [CW-1:0]                        cb,
  input  logic [CW-1:0]                        cr,
  input  logic [CW-1:0]                        cb_lo,
  input  logic [CW-1:0]                        cb_hi,
  input  logic [CW-1:0]                        cr_lo,
  input  logic [CW-1:0]                        cr_hi,
  output logic                                 clear_busy,
  output logic                                 pix_hit,
  output logic                                 box_valid,
  output logic                                 box_found,
  output logic [9:0]                           x_min,
  output logic [9:0]                           x_max,
  output logic [9:0]                           y_min,
  output logic [9:0]                           y_max,
  output logic [$clog2(H_ACT*V_ACT+1)-1:0]     hit_count
);

  localparam int DEPTH = H_ACT * V_ACT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam logic [10:0] H_LIM  = 11'(H_ACT);
  localparam logic [10:0] V_LIM  = 11'(V_ACT);
  localparam logic [9:0]  X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;

  logic [HIST_BITS-1:0]  mem [DEPTH];
  logic [HIST_BITS-1:0]  ram_rdata_q;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [HIST_BITS-1:0]  ram_wdata;

  logic                  accept;
  logic [AW-1:0]         rd_addr;
  logic                  match0;
  logic                  last0;

  logic                  s1_valid_q, s1_valid_d;
  logic [AW-1:0]         s1_addr_q, s1_addr_d;
  logic                  s1_match_q, s1_match_d;
  logic                  s1_last_q, s1_last_d;
  logic [9:0]            s1_x_q, s1_x_d;
  logic [9:0]            s1_y_q, s1_y_d;
  logic                  s1_fwd_q, s1_fwd_d;
  logic [HIST_BITS-1:0]  s1_fwd_data_q, s1_fwd_data_d;

  logic [HIST_BITS-1:0]  old_hist;
  logic [HIST_BITS-1:0]  new_hist;
  logic                  persistent;

  logic [9:0]            acc_xmin_q, acc_xmin_d;
  logic [9:0]            acc_xmax_q, acc_xmax_d;
  logic [9:0]            acc_ymin_q, acc_ymin_d;
  logic [9:0]            acc_ymax_q, acc_ymax_d;
  logic [CNTW-1:0]       acc_cnt_q, acc_cnt_d;
  logic [9:0]            nx_min, nx_max, ny_min, ny_max;
  logic [CNTW-1:0]       n_cnt;

  logic                  pix_hit_q, pix_hit_d;
  logic                  box_valid_q, box_valid_d;
  logic                  box_found_q, box_found_d;
  logic [9:0]            x_min_q, x_min_d;
  logic [9:0]            x_max_q, x_max_d;
  logic [9:0]            y_min_q, y_min_d;
  logic [9:0]            y_max_q, y_max_d;
  logic [CNTW-1:0]       hit_count_q, hit_count_d;

  // Stage 0: accept, address and window compare
  always_comb begin
    accept  = (state_q == ST_RUN) && pix_valid && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    rd_addr = AW'(y) * AW'(H_ACT) + AW'(x);
    match0  = (cb >= cb_lo) && (cb <= cb_hi) && (cr >= cr_lo) && (cr <= cr_hi);
    last0   = (x == X_LAST) && (y == Y_LAST);
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Stage 1: the RAM read misses a write landing on the same edge, so that write is bypassed
  always_comb begin
    old_hist   = s1_fwd_q ? s1_fwd_data_q : ram_rdata_q;
    new_hist   = HIST_BITS'({old_hist, s1_match_q});
    persistent = &new_hist[PERSIST-1:0];

    s1_valid_d    = accept;
    s1_addr_d     = rd_addr;
    s1_match_d    = match0;
    s1_last_d     = last0;
    s1_x_d        = x;
    s1_y_d        = y;
    s1_fwd_d      = accept && s1_valid_q && (rd_addr == s1_addr_q);
    s1_fwd_data_d = new_hist;

    ram_we    = (state_q == ST_CLEAR) ? 1'b1 : s1_valid_q;
    ram_waddr = (state_q == ST_CLEAR) ? clr_addr_q : s1_addr_q;
    ram_wdata = (state_q == ST_CLEAR) ? '0 : new_hist;
  end

  always_comb begin
    nx_min = acc_xmin_q;
    nx_max = acc_xmax_q;
    ny_min = acc_ymin_q;
    ny_max = acc_ymax_q;
    n_cnt  = acc_cnt_q;
    if (s1_valid_q && persistent) begin
      if (s1_x_q < acc_xmin_q) nx_min = s1_x_q;
      if (s1_x_q > acc_xmax_q) nx_max = s1_x_q;
      if (s1_y_q < acc_ymin_q) ny_min = s1_y_q;
      if (s1_y_q > acc_ymax_q) ny_max = s1_y_q;
      n_cnt = acc_cnt_q + CNTW'(1);
    end

    acc_xmin_d  = nx_min;
    acc_xmax_d  = nx_max;
    acc_ymin_d  = ny_min;
    acc_ymax_d  = ny_max;
    acc_cnt_d   = n_cnt;
    pix_hit_d   = s1_valid_q && persistent;
    box_valid_d = 1'b0;
    box_found_d = box_found_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    hit_count_d = hit_count_q;

    // Frame closes when the bottom-right pixel leaves stage 1, its own hit included
    if (s1_valid_q && s1_last_q) begin
      box_valid_d = 1'b1;
      box_found_d = (n_cnt != '0);
      x_min_d     = (n_cnt != '0) ? nx_min : '0;
      x_max_d     = (n_cnt != '0) ? nx_max : '0;
      y_min_d     = (n_cnt != '0) ? ny_min : '0;
      y_max_d     = (n_cnt != '0) ? ny_max : '0;
      hit_count_d = n_cnt;
      acc_xmin_d  = X_LAST;
      acc_xmax_d  = '0;
      acc_ymin_d  = Y_LAST;
      acc_ymax_d  = '0;
      acc_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (accept) ram_rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_match_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      acc_xmin_q    <= X_LAST;
      acc_xmax_q    <= '0;
      acc_ymin_q    <= Y_LAST;
      acc_ymax_q    <= '0;
      acc_cnt_q     <= '0;
      pix_hit_q     <= 1'b0;
      box_valid_q   <= 1'b0;
      box_found_q   <= 1'b0;
      x_min_q       <= '0;
      x_max_q       <= '0;
      y_min_q       <= '0;
      y_max_q       <= '0;
      hit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_match_q    <= s1_match_d;
      s1_last_q     <= s1_last_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      acc_xmin_q    <= acc_xmin_d;
      acc_xmax_q    <= acc_xmax_d;
      acc_ymin_q    <= acc_ymin_d;
      acc_ymax_q    <= acc_ymax_d;
      acc_cnt_q     <= acc_cnt_d;
      pix_hit_q     <= pix_hit_d;
      box_valid_q   <= box_valid_d;
      box_found_q   <= box_found_d;
      x_min_q       <= x_min_d;
      x_max_q       <= x_max_d;
      y_min_q       <= y_min_d;
      y_max_q       <= y_max_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign pix_hit    = pix_hit_q;
  assign box_valid  = box_valid_q;
  assign box_found  = box_found_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_color_box_tracker.sv
// tb/tb_color_box_tracker.sv - randomized and directed bench for color_box_tracker against a behavioural model
module tb_color_box_tracker;
  localparam int H = 16, V = 8, HB = 4, P = 3, CW = 8;
  localparam int DEPTH = H * V;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset = 1'b1, pix_valid = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [CW-1:0] cb = '0, cr = '0;
  logic [CW-1:0] cb_lo = 8'd100, cb_hi = 8'd120, cr_lo = 8'd100, cr_hi = 8'd120;
  logic clear_busy, pix_hit, box_valid, box_found;
  logic [9:0] x_min, x_max, y_min, y_max;
  logic [CNTW-1:0] hit_count;

  always #5 clk = ~clk;

  color_box_tracker #(.H_ACT(H), .V_ACT(V), .HIST_BITS(HB), .PERSIST(P), .CW(CW)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .x(x), .y(y), .cb(cb), .cr(cr),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .clear_busy(clear_busy), .pix_hit(pix_hit), .box_valid(box_valid), .box_found(box_found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .hit_count(hit_count));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-pixel history as a shift of match bits, frame stats gathered per accepted pixel
  typedef struct {bit hit; bit bv; bit found; int xmin; int xmax; int ymin; int ymax; int cnt;} ev_t;
  int   hist [DEPTH];
  bit   m_clear = 1'b1;
  int   m_cnt = 0;
  int   ax_min, ax_max, ay_min, ay_max, acnt;
  ev_t  pend, cur;
  int   h_found, h_xmin, h_xmax, h_ymin, h_ymax, h_cnt;
  bit   armed = 1'b0;

  always @(posedge clk) begin : model
    ev_t e;
    int a, hv;
    bit m;
    e = '{default: 0};
    if (reset) begin
      foreach (hist[i]) hist[i] = 0;
      m_clear = 1'b1; m_cnt = 0;
      ax_min = H - 1; ay_min = V - 1; ax_max = 0; ay_max = 0; acnt = 0;
      pend = e; cur = e;
      h_found = 0; h_xmin = 0; h_xmax = 0; h_ymin = 0; h_ymax = 0; h_cnt = 0;
      armed = 1'b1;
    end else begin
      cur = pend;
      if (m_clear) begin
        m_cnt++;
        if (m_cnt == DEPTH) m_clear = 1'b0;
      end else if (pix_valid && x < H && y < V) begin
        a  = int'(y) * H + int'(x);
        m  = (cb >= cb_lo) && (cb <= cb_hi) && (cr >= cr_lo) && (cr <= cr_hi);
        hv = ((hist[a] << 1) | int'(m)) % (1 << HB);
        hist[a] = hv;
        e.hit = (hv % (1 << P)) == (1 << P) - 1;
        if (e.hit) begin
          if (int'(x) < ax_min) ax_min = int'(x);
          if (int'(x) > ax_max) ax_max = int'(x);
          if (int'(y) < ay_min) ay_min = int'(y);
          if (int'(y) > ay_max) ay_max = int'(y);
          acnt++;
        end
        if (x == H - 1 && y == V - 1) begin
          e.bv = 1'b1;
          e.found = (acnt != 0);
          e.xmin = e.found ? ax_min : 0;
          e.xmax = e.found ? ax_max : 0;
          e.ymin = e.found ? ay_min : 0;
          e.ymax = e.found ? ay_max : 0;
          e.cnt = acnt;
          ax_min = H - 1; ay_min = V - 1; ax_max = 0; ay_max = 0; acnt = 0;
        end
      end
      pend = e;
      if (cur.bv) begin
        h_found = cur.found; h_xmin = cur.xmin; h_xmax = cur.xmax;
        h_ymin = cur.ymin; h_ymax = cur.ymax; h_cnt = cur.cnt;
      end
    end
  end

  int n_box = 0;
  int r_found, r_xmin, r_xmax, r_ymin, r_ymax, r_cnt;

  always @(negedge clk) begin : compare
    if (armed) begin
      chk("clear_busy", clear_busy, m_clear);
      chk("pix_hit", pix_hit, cur.hit);
      chk("box_valid", box_valid, cur.bv);
      chk("box_found", box_found, h_found);
      chk("x_min", x_min, h_xmin);
      chk("x_max", x_max, h_xmax);
      chk("y_min", y_min, h_ymin);
      chk("y_max", y_max, h_ymax);
      chk("hit_count", hit_count, h_cnt);
      if (box_valid === 1'b1) begin
        n_box++;
        r_found = box_found; r_xmin = x_min; r_xmax = x_max;
        r_ymin = y_min; r_ymax = y_max; r_cnt = hit_count;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pix_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (clear_busy === 1'b1 && n < 3 * DEPTH) begin tick(); n++; end
    chk("clear_done", clear_busy, 0);
  endtask

  function automatic logic [7:0] chroma(input int mode, input int xx, input int yy);
    case (mode)
      0: return (xx >= 5 && xx <= 9 && yy >= 2 && yy <= 4) ? 8'd110 : 8'd0;
      1: return (xx == H - 1 && yy == V - 1) ? 8'd110 : 8'd0;
      default: return 8'($urandom_range(0, 99));
    endcase
  endfunction

  task automatic frame(input int mode, input int npix = DEPTH, input int sx = -1, input int sy = -1);
    int k;
    logic [7:0] c;
    k = 0;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        if (k < npix) begin
          c = chroma(mode, xx, yy);
          if (xx == sx && yy == sy) c = 8'd0;
          pix_valid = 1'b1; x = 10'(xx); y = 10'(yy); cb = c; cr = c;
          tick();
        end
        k++;
      end
    end
    pix_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic chk_box(input string tag, input int f, input int x0, input int x1,
                         input int y0, input int y1, input int c);
    chk({tag, "_found"}, r_found, f);
    chk({tag, "_xmin"}, r_xmin, x0);
    chk({tag, "_xmax"}, r_xmax, x1);
    chk({tag, "_ymin"}, r_ymin, y0);
    chk({tag, "_ymax"}, r_ymax, y1);
    chk({tag, "_cnt"}, r_cnt, c);
  endtask

  task automatic seq4(input int xa, input int ya, input int xb, input int yb, output logic [5:0] hits);
    hits = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin pix_valid = 1'b1; x = 10'(xa); y = 10'(ya); cb = 8'd110; cr = 8'd110; end
      else if (i == 3) begin pix_valid = 1'b1; x = 10'(xb); y = 10'(yb); cb = 8'd110; cr = 8'd110; end
      else pix_valid = 1'b0;
      tick();
      hits[i] = pix_hit;
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    int n, nb0;
    logic [5:0] hits;

    // Clear length after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 2 * DEPTH) begin n++; tick(); end
    chk("clear_cycles", n, DEPTH);
    chk("rst_box_found", box_found, 0);
    chk("rst_hit_count", hit_count, 0);

    // Three non-matching frames
    nb0 = n_box;
    repeat (3) frame(3);
    chk("nomatch_frames", n_box - nb0, 3);
    chk_box("nomatch", 0, 0, 0, 0, 0, 0);

    // Box build-up over three frames, then drop-out of one pixel
    do_reset(); wait_clear();
    frame(0); chk_box("box_f1", 0, 0, 0, 0, 0, 0);
    frame(0); chk_box("box_f2", 0, 0, 0, 0, 0, 0);
    frame(0); chk_box("box_f3", 1, 5, 9, 2, 4, 15);
    frame(0, DEPTH, 5, 2); chk_box("box_f4", 1, 5, 9, 2, 4, 14);
    frame(0); chk_box("box_f5", 1, 5, 9, 2, 4, 14);
    frame(0); chk_box("box_f6", 1, 5, 9, 2, 4, 14);
    frame(0); chk_box("box_f7", 1, 5, 9, 2, 4, 15);

    // Single bottom-right pixel, then an impossible window
    do_reset(); wait_clear();
    repeat (3) frame(1);
    chk_box("corner", 1, H - 1, H - 1, V - 1, V - 1, 1);
    cb_lo = 8'd200; cb_hi = 8'd10;
    frame(1);
    chk_box("lo_gt_hi", 0, 0, 0, 0, 0, 0);
    cb_lo = 8'd100; cb_hi = 8'd120;

    // Reset mid-frame: no strobe until clear completes, then results repeat
    do_reset(); wait_clear();
    frame(0); frame(0);
    frame(0, DEPTH / 2);
    nb0 = n_box;
    do_reset(); wait_clear();
    chk("no_box_in_reset", n_box - nb0, 0);
    frame(0); chk_box("rerun_f1", 0, 0, 0, 0, 0, 0);
    frame(0); chk_box("rerun_f2", 0, 0, 0, 0, 0, 0);
    frame(0); chk_box("rerun_f3", 1, 5, 9, 2, 4, 15);

    // Same address back-to-back and out-of-range drops
    do_reset(); wait_clear();
    seq4(3, 3, 3, 3, hits);
    chk("fwd_seq", hits[4:1], 4'b1100);
    seq4(H, 0, 0, 1, hits);
    chk("oor_seq", hits[4:1], 4'b0000);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 4000; i++) begin
      reset = (i >= 2000 && i < 2003);
      pix_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        x = 10'($urandom_range(12, H + 1)); y = 10'($urandom_range(5, V));
      end else begin
        x = 10'($urandom_range(0, H + 1)); y = 10'($urandom_range(0, V));
      end
      cb = 8'($urandom_range(95, 125)); cr = 8'($urandom_range(98, 122));
      tick();
    end
    reset = 1'b0; pix_valid = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/color_box_tracker.md
COLOR_BOX_TRACKER -- requirements
Module: color_box_tracker

Interface
REQ-001 SHALL provide parameters: H_ACT, default 640, active pixels per line; V_ACT, default 480, active lines per frame; HIST_BITS, default 4, per-pixel history depth; PERSIST, default 3, consecutive matching frames required (1..HIST_BITS); CW, default 8, chroma width.
REQ-002 SHALL have ports:
- clk  in  1  clock; reset is synchronous, active-high, named reset.
- reset  in  1  synchronous active-high reset.
- pix_valid  in  1  pixel strobe.
- x  in  10  pixel column.
- y  in  10  pixel row.
- cb, cr  in  CW  chroma samples.
- cb_lo, cb_hi, cr_lo, cr_hi  in  CW each  inclusive match window.
- clear_busy  out  1  history clear in progress.
- pix_hit  out  1  persistent match for the pixel issued 2 cycles earlier.
- box_valid  out  1  one-cycle frame-result strobe.
- box_found  out  1  at least one persistent pixel in the last frame.
- x_min, x_max  out  10 each  bounding columns.
- y_min, y_max  out  10 each  bounding rows.
- hit_count  out  $clog2(H_ACT*V_ACT+1)  persistent pixels in the last frame.

Function
REQ-003 SHALL hold an internal history RAM of H_ACT*V_ACT words x HIST_BITS, addressed y*H_ACT+x, single write and single read port, 1-cycle synchronous read.
REQ-004 SHALL implement states CLEAR and RUN; reset enters CLEAR.
REQ-005 In CLEAR, SHALL write zero to one address per cycle, ascending from 0; after address H_ACT*V_ACT-1 it SHALL enter RUN on the next cycle. clear_busy is 1 exactly while in CLEAR.
REQ-006 In CLEAR, SHALL ignore pix_valid; pix_hit and box_valid stay 0.
REQ-007 In RUN, SHALL accept a pixel when pix_valid=1, x<H_ACT and y<V_ACT; out-of-range pixels SHALL be dropped with no RAM access and no pix_hit.
REQ-008 match = (cb_lo<=cb<=cb_hi) AND (cr_lo<=cr<=cr_hi), unsigned, sampled at acceptance; lo>hi SHALL never match.
REQ-009 Stage 0 (accept cycle) SHALL issue the read. Stage 1 SHALL form new = {old[HIST_BITS-2:0], match} and write it back.
REQ-010 Stage 1 SHALL set persistent = 1 when the low PERSIST bits of new are all 1. pix_hit SHALL be registered, valid 2 cycles after acceptance, and 0 on cycles with no stage-1 pixel.
REQ-011 If the stage-0 address equals the address being written in stage 1 on the same cycle, SHALL forward the write data instead of the RAM output.
REQ-012 For each persistent pixel, SHALL update running accumulators: xmin/xmax/ymin/ymax compare-and-update, and count+1.
REQ-013 Accumulator reset values SHALL be xmin=H_ACT-1, ymin=V_ACT-1, xmax=0, ymax=0, count=0.
REQ-014 When the pixel at (H_ACT-1, V_ACT-1) leaves stage 1, with its own contribution included, the block SHALL on the next cycle:
- copy the accumulators to the outputs;
- set box_found = (count!=0);
- pulse box_valid for one cycle;
- reset the accumulators.
REQ-015 When box_found=0, SHALL drive x_min, x_max, y_min and y_max to 0.
REQ-016 Outputs SHALL hold between box_valid pulses.
REQ-017 Missing pixels within a frame SHALL leave their history untouched, with no aging.
REQ-018 Back-to-back accepts every cycle SHALL be supported with no stalls.

Reset
REQ-019 Reset asserted in any state, including mid-CLEAR or mid-frame, SHALL restart CLEAR from address 0, flush both pipeline stages, and clear the accumulators.
REQ-020 Reset values: clear_busy=1, pix_hit=0, box_valid=0, box_found=0, x_min=x_max=y_min=y_max=0, hit_count=0.

Verification
REQ-021 Reset, then idle: clear_busy=1 for exactly H_ACT*V_ACT cycles, then 0. A full RAM readback through 3 non-matching frames gives pix_hit=0 everywhere.
REQ-022 With window cb 100..120 and cr 100..120, feed an identical full frame with pixels (100..109, 50..59) at cb=cr=110 and all others at 0:
- frames 1-2: box_valid with box_found=0 and coords 0;
- frame 3: box_found=1, x_min=100, x_max=109, y_min=50, y_max=59, hit_count=100.
REQ-023 After 3 matching frames, make pixel (100,50) non-matching in frame 4: pix_hit=0 for it. Restore it: pix_hit stays 0 until 3 more matching frames.
REQ-024 Boundary: a single persistent pixel at (639,479) gives x_min=x_max=639, y_min=y_max=479, hit_count=1, with the strobe on the cycle after its stage 1. Window cb_lo=200, cb_hi=10 never matches.
REQ-025 Assert reset mid-frame-3 of REQ-022: no box_valid until CLEAR completes. The following 3 frames reproduce the frame-1..3 results exactly.
REQ-026 Out-of-range (x=640, y=0) with pix_valid: no RAM write and no pix_hit; the same address used twice in consecutive cycles shows correct forwarded history.
